// File: rtl/vcr_master_if.sv
// Host command, write/read byte streams and the VCR bus, bundled for vcr_master.
interface vcr_master_if;
  // host command channel
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wr_len;
  logic [7:0] cmd_rd_len;
  // write byte stream
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  // read byte stream
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  // status
  logic       busy;
  logic       done;
  // VCR bus toward the responder
  logic       vcr_cs;
  logic [7:0] vcr_out;
  logic       vcr_oe;
  logic [7:0] vcr_in;
  logic       vcr_dir;
  logic       vcr_set_addr;
  logic       vcr_set_data;

  modport master (
    input  cmd_valid, cmd_addr, cmd_wr_len, cmd_rd_len,
    input  wr_data, wr_valid, rd_ready, vcr_in,
    output cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
    output vcr_cs, vcr_out, vcr_oe, vcr_dir, vcr_set_addr, vcr_set_data
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_wr_len, cmd_rd_len,
    output wr_data, wr_valid, rd_ready, vcr_in,
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
    input  vcr_cs, vcr_out, vcr_oe, vcr_dir, vcr_set_addr, vcr_set_data
  );
endinterface

// File: rtl/vcr_master.sv
// VCR bus initiator: address strobe, byte writes, then byte reads, each strobe
// paced so a 2-flop synchroniser plus edge detector on the responder sees it.
module vcr_master #(
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES    = 4,
  parameter int unsigned TURN_CYCLES   = 4
) (
  input logic          IFCLK,
  input logic          RESET,
  vcr_master_if.master bus
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_A_SETUP = 4'd1;
  localparam logic [3:0] S_A_STB   = 4'd2;
  localparam logic [3:0] S_A_GAP   = 4'd3;
  localparam logic [3:0] S_W_WAIT  = 4'd4;
  localparam logic [3:0] S_W_SETUP = 4'd5;
  localparam logic [3:0] S_W_STB   = 4'd6;
  localparam logic [3:0] S_W_GAP   = 4'd7;
  localparam logic [3:0] S_TURN    = 4'd8;
  localparam logic [3:0] S_R_HOLD  = 4'd9;
  localparam logic [3:0] S_R_STB   = 4'd10;
  localparam logic [3:0] S_R_GAP   = 4'd11;
  localparam logic [3:0] S_FIN     = 4'd12;

  // Phase counter is loaded with (length - 1) and the state exits at zero.
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] GAP_LD    = 4'(GAP_CYCLES - 1);
  localparam logic [3:0] TURN_LD   = 4'(TURN_CYCLES - 1);

  logic [3:0] state_q, state_d;
  logic [3:0] phase_q, phase_d;
  logic [7:0] wr_len_q, wr_len_d;
  logic [7:0] rd_len_q, rd_len_d;
  logic [7:0] vcr_in_q;
  logic       cmd_ready_q, cmd_ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       wr_ready_q, wr_ready_d;
  logic       rd_valid_q, rd_valid_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       cs_q, cs_d;
  logic [7:0] out_q, out_d;
  logic       oe_q, oe_d;
  logic       dir_q, dir_d;
  logic       set_addr_q, set_addr_d;
  logic       set_data_q, set_data_d;
  logic       phase_end;

  assign phase_end = (phase_q == 4'd0);

  // Next-state and next-output logic for the whole transaction sequence.
  always_comb begin
    // NOTE: every _d gets its hold value first, so no branch can infer a latch.
    state_d     = state_q;
    phase_d     = phase_end ? 4'd0 : phase_q - 4'd1;
    wr_len_d    = wr_len_q;
    rd_len_d    = rd_len_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    wr_ready_d  = 1'b0;
    rd_valid_d  = rd_valid_q;
    rd_data_d   = rd_data_q;
    cs_d        = cs_q;
    out_d       = out_q;
    oe_d        = oe_q;
    dir_d       = dir_q;
    set_addr_d  = set_addr_q;
    set_data_d  = set_data_q;

    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          wr_len_d    = bus.cmd_wr_len;
          rd_len_d    = bus.cmd_rd_len;
          out_d       = bus.cmd_addr;
          oe_d        = 1'b1;
          dir_d       = 1'b0;
          cs_d        = 1'b1;
          busy_d      = 1'b1;
          state_d     = S_A_SETUP;
          phase_d     = SETUP_LD;
        end
      end
      S_A_SETUP: if (phase_end) begin
        set_addr_d = 1'b1;
        state_d    = S_A_STB;
        phase_d    = STROBE_LD;
      end
      S_A_STB: if (phase_end) begin
        set_addr_d = 1'b0;
        state_d    = S_A_GAP;
        phase_d    = GAP_LD;
      end
      S_A_GAP, S_W_GAP: if (phase_end) begin
        if (wr_len_q != 8'd0) begin
          state_d = S_W_WAIT;
          phase_d = 4'd0;
        end else if (rd_len_q != 8'd0) begin
          // Release the bus and flip direction on the same edge.
          oe_d    = 1'b0;
          dir_d   = 1'b1;
          state_d = S_TURN;
          phase_d = TURN_LD;
        end else begin
          state_d = S_FIN;
          phase_d = 4'd0;
        end
      end
      S_W_WAIT: if (bus.wr_valid) begin
        wr_ready_d = 1'b1;
        out_d      = bus.wr_data;
        wr_len_d   = wr_len_q - 8'd1;
        state_d    = S_W_SETUP;
        phase_d    = SETUP_LD;
      end
      S_W_SETUP: if (phase_end) begin
        set_data_d = 1'b1;
        state_d    = S_W_STB;
        phase_d    = STROBE_LD;
      end
      S_W_STB, S_R_STB: if (phase_end) begin
        set_data_d = 1'b0;
        state_d    = (state_q == S_W_STB) ? S_W_GAP : S_R_GAP;
        phase_d    = GAP_LD;
      end
      S_TURN: if (phase_end) begin
        rd_data_d  = vcr_in_q;
        rd_valid_d = 1'b1;
        state_d    = S_R_HOLD;
        phase_d    = 4'd0;
      end
      S_R_HOLD: if (bus.rd_ready && rd_valid_q) begin
        rd_valid_d = 1'b0;
        rd_len_d   = rd_len_q - 8'd1;
        set_data_d = 1'b1;
        state_d    = S_R_STB;
        phase_d    = STROBE_LD;
      end
      S_R_GAP: if (phase_end) begin
        if (rd_len_q != 8'd0) begin
          rd_data_d  = vcr_in_q;
          rd_valid_d = 1'b1;
          state_d    = S_R_HOLD;
        end else begin
          state_d = S_FIN;
        end
        phase_d = 4'd0;
      end
      S_FIN: begin
        done_d  = 1'b1;
        cs_d    = 1'b0;
        dir_d   = 1'b0;
        oe_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        phase_d = 4'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs, with synchronous reset to the idle values.
  always_ff @(posedge IFCLK) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (RESET) begin
      state_q     <= S_IDLE;
      phase_q     <= 4'd0;
      wr_len_q    <= 8'd0;
      rd_len_q    <= 8'd0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= 8'd0;
      cs_q        <= 1'b0;
      out_q       <= 8'd0;
      oe_q        <= 1'b0;
      dir_q       <= 1'b0;
      set_addr_q  <= 1'b0;
      set_data_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      wr_len_q    <= wr_len_d;
      rd_len_q    <= rd_len_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_ready_q  <= wr_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      cs_q        <= cs_d;
      out_q       <= out_d;
      oe_q        <= oe_d;
      dir_q       <= dir_d;
      set_addr_q  <= set_addr_d;
      set_data_q  <= set_data_d;
    end
  end

  // Bus sample register; every read byte is taken from here.
  always_ff @(posedge IFCLK) begin
    // NOTE: a pure data pipeline register needs no reset; it is never read before TURN fills it.
    vcr_in_q <= bus.vcr_in;
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.wr_ready     = wr_ready_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.vcr_cs       = cs_q;
  assign bus.vcr_out      = out_q;
  assign bus.vcr_oe       = oe_q;
  assign bus.vcr_dir      = dir_q;
  assign bus.vcr_set_addr = set_addr_q;
  assign bus.vcr_set_data = set_data_q;

endmodule
